// File: rtl/doa_sequencer_pkg.sv
// Shared types and constants for the DOA frame sequencer.
// Holds the state encoding, stage codes reported on a watchdog timeout, and datapath widths.
package doa_pkg;

   localparam int DOA_W   = 8;
   localparam int FRAME_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_FFT,
      ST_DETECT,
      ST_BEAM,
      ST_HOLD,
      ST_ERROR
   } state_t;

   localparam logic [2:0] STG_NONE    = 3'd0;
   localparam logic [2:0] STG_CAPTURE = 3'd1;
   localparam logic [2:0] STG_FFT     = 3'd2;
   localparam logic [2:0] STG_DETECT  = 3'd3;
   localparam logic [2:0] STG_BEAM    = 3'd4;

   function automatic logic is_stage(input state_t s);
      return (s == ST_CAPTURE) || (s == ST_FFT) || (s == ST_DETECT) || (s == ST_BEAM);
   endfunction

   function automatic logic [2:0] stage_code(input state_t s);
      case (s)
         ST_CAPTURE: return STG_CAPTURE;
         ST_FFT:     return STG_FFT;
         ST_DETECT:  return STG_DETECT;
         ST_BEAM:    return STG_BEAM;
         default:    return STG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/doa_sequencer_if.sv
// Control, stage handshake and result channel bundle for the DOA sequencer.
// The master side is the surrounding system; the slave side is the sequencer itself.
interface doa_sequencer_if;
   import doa_pkg::*;

   logic               start;
   logic               abort;
   logic               clr_err;
   logic               cap_start;
   logic               cap_done;
   logic               fft_start;
   logic               fft_done;
   logic               det_start;
   logic               det_done;
   logic               wb_go;
   logic               wb_done;
   logic [DOA_W-1:0]   wb_doa;
   logic               ram_sel;
   logic               res_valid;
   logic               res_ready;
   logic [DOA_W-1:0]   res_doa;
   logic [FRAME_W-1:0] res_frame;
   logic               busy;
   logic               err;
   logic [2:0]         err_stage;

   modport master (
      output start, abort, clr_err, cap_done, fft_done, det_done, wb_done, wb_doa, res_ready,
      input  cap_start, fft_start, det_start, wb_go, ram_sel, res_valid, res_doa, res_frame,
             busy, err, err_stage
   );

   modport slave (
      input  start, abort, clr_err, cap_done, fft_done, det_done, wb_done, wb_doa, res_ready,
      output cap_start, fft_start, det_start, wb_go, ram_sel, res_valid, res_doa, res_frame,
             busy, err, err_stage
   );

endinterface

// File: rtl/doa_sequencer_stage_timer.sv
// Per-stage watchdog: down-counter loaded on stage entry, expires at terminal count zero.
// Loaded with TIMEOUT_CYCLES-1 so expiry lands on the last cycle a stage is allowed to run.
module stage_timer #(
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/doa_sequencer.sv
// DOA frame sequencer: capture -> FFT -> detect -> beam scan -> result hold, with watchdog.
// state   | meaning
// IDLE    | waiting for start or a pending request
// CAPTURE | sample capture running
// FFT     | FFT running
// DETECT  | max-bin frequency detect running
// BEAM    | beam scan owns the FFT RAM read port
// HOLD    | result presented, waiting for res_ready
// ERROR   | stage watchdog expired, waiting for clr_err
module doa_sequencer
   import doa_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter bit AUTO_RUN       = 1'b0
) (
   input logic       clk,
   input logic       reset_n,
   doa_sequencer_if.slave bus
);

   state_t             state_q, state_d;
   logic               pending_q, pending_d;
   logic               cap_start_q, cap_start_d;
   logic               fft_start_q, fft_start_d;
   logic               det_start_q, det_start_d;
   logic               wb_go_q, wb_go_d;
   logic               ram_sel_q, ram_sel_d;
   logic               busy_q, busy_d;
   logic               res_valid_q, res_valid_d;
   logic [DOA_W-1:0]   res_doa_q, res_doa_d;
   logic [FRAME_W-1:0] res_frame_q, res_frame_d;
   logic               err_q, err_d;
   logic [2:0]         err_stage_q, err_stage_d;
   logic               entering, handshake, tmr_expired;

   stage_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_i    (entering && is_stage(state_d)),
      .clr_i     (!is_stage(state_d)),
      .en_i      (is_stage(state_q)),
      .expired_o (tmr_expired)
   );

   // A stage's done pulse is tested before expiry, so done wins on the expiry cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (bus.start || pending_q) state_d = ST_CAPTURE;
         ST_CAPTURE: if (bus.cap_done) state_d = ST_FFT;    else if (tmr_expired) state_d = ST_ERROR;
         ST_FFT:     if (bus.fft_done) state_d = ST_DETECT; else if (tmr_expired) state_d = ST_ERROR;
         ST_DETECT:  if (bus.det_done) state_d = ST_BEAM;   else if (tmr_expired) state_d = ST_ERROR;
         ST_BEAM:    if (bus.wb_done)  state_d = ST_HOLD;   else if (tmr_expired) state_d = ST_ERROR;
         ST_HOLD: begin
            if (res_valid_q && bus.res_ready) state_d = (AUTO_RUN || pending_q) ? ST_CAPTURE : ST_IDLE;
         end
         ST_ERROR:   if (bus.clr_err) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      if (bus.abort) state_d = ST_IDLE;
   end

   assign entering  = (state_d != state_q);
   assign handshake = (state_q == ST_HOLD) && res_valid_q && bus.res_ready && !bus.abort;

   always_comb begin
      pending_d   = pending_q;
      err_d       = err_q;
      err_stage_d = err_stage_q;
      if (bus.abort || ((state_q == ST_ERROR) && (state_d == ST_IDLE))) begin
         pending_d = 1'b0;
      end else if (entering && (state_d == ST_CAPTURE)) begin
         pending_d = 1'b0;
      end else if (bus.start && (state_q != ST_IDLE)) begin
         pending_d = 1'b1;
      end
      if ((state_q != ST_ERROR) && (state_d == ST_ERROR)) begin
         err_d       = 1'b1;
         err_stage_d = stage_code(state_q);
      end else if (bus.clr_err && !bus.abort) begin
         err_d       = 1'b0;
         err_stage_d = STG_NONE;
      end
      cap_start_d = entering && (state_d == ST_CAPTURE);
      fft_start_d = entering && (state_d == ST_FFT);
      det_start_d = entering && (state_d == ST_DETECT);
      wb_go_d     = entering && (state_d == ST_BEAM);
      ram_sel_d   = (state_d == ST_BEAM);
      busy_d      = is_stage(state_d);
      res_valid_d = (state_d == ST_HOLD);
      res_doa_d   = ((state_q == ST_BEAM) && (state_d == ST_HOLD)) ? bus.wb_doa : res_doa_q;
      res_frame_d = handshake ? (res_frame_q + FRAME_W'(1)) : res_frame_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         pending_q   <= 1'b0;
         cap_start_q <= 1'b0;
         fft_start_q <= 1'b0;
         det_start_q <= 1'b0;
         wb_go_q     <= 1'b0;
         ram_sel_q   <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_doa_q   <= '0;
         res_frame_q <= '0;
         err_q       <= 1'b0;
         err_stage_q <= STG_NONE;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         cap_start_q <= cap_start_d;
         fft_start_q <= fft_start_d;
         det_start_q <= det_start_d;
         wb_go_q     <= wb_go_d;
         ram_sel_q   <= ram_sel_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         res_doa_q   <= res_doa_d;
         res_frame_q <= res_frame_d;
         err_q       <= err_d;
         err_stage_q <= err_stage_d;
      end
   end

   assign bus.cap_start = cap_start_q;
   assign bus.fft_start = fft_start_q;
   assign bus.det_start = det_start_q;
   assign bus.wb_go     = wb_go_q;
   assign bus.ram_sel   = ram_sel_q;
   assign bus.busy      = busy_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_doa   = res_doa_q;
   assign bus.res_frame = res_frame_q;
   assign bus.err       = err_q;
   assign bus.err_stage = err_stage_q;

endmodule

// File: tb/tb_doa_sequencer.sv
// Directed bench for doa_sequencer with a short watchdog (16 cycles).
// A per-cycle vector table covers the basic flow; hand sequences cover timeout, abort and reset corners.
module tb_doa_sequencer;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   n_cs = 0, n_fs = 0, n_ds = 0, n_wg = 0;

   doa_sequencer_if bus ();

   doa_sequencer #(.TIMEOUT_CYCLES(16), .AUTO_RUN(1'b0)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  in_b;      // start abort cap_done fft_done det_done wb_done res_ready
      logic [7:0]  doa_in;
      logic [6:0]  exp_b;     // cap_start fft_start det_start wb_go ram_sel busy res_valid
      logic [7:0]  exp_doa;
      logic [15:0] exp_frame;
   } vec_t;

   vec_t vecs[16];

   task automatic step();
      @(posedge clk);
      #1;
      n_cs += int'(bus.cap_start);
      n_fs += int'(bus.fft_start);
      n_ds += int'(bus.det_start);
      n_wg += int'(bus.wb_go);
   endtask

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   function automatic logic [39:0] all_outs();
      return 40'({bus.cap_start, bus.fft_start, bus.det_start, bus.wb_go, bus.ram_sel,
                  bus.res_valid, bus.busy, bus.err, bus.err_stage, bus.res_doa, bus.res_frame});
   endfunction

   task automatic to_beam();
      bus.start = 1'b1;    step(); bus.start = 1'b0;
      bus.cap_done = 1'b1; step(); bus.cap_done = 1'b0;
      bus.fft_done = 1'b1; step(); bus.fft_done = 1'b0;
      bus.det_done = 1'b1; step(); bus.det_done = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{7'b1000000, 8'h00, 7'b1000010, 8'hDD, 16'd1};
      vecs[1]  = '{7'b0000000, 8'h00, 7'b0000010, 8'hDD, 16'd1};
      vecs[2]  = '{7'b0001000, 8'h00, 7'b0000010, 8'hDD, 16'd1};
      vecs[3]  = '{7'b0010000, 8'h00, 7'b0100010, 8'hDD, 16'd1};
      vecs[4]  = '{7'b0000100, 8'h00, 7'b0000010, 8'hDD, 16'd1};
      vecs[5]  = '{7'b0001000, 8'h00, 7'b0010010, 8'hDD, 16'd1};
      vecs[6]  = '{7'b0000100, 8'h00, 7'b0001110, 8'hDD, 16'd1};
      vecs[7]  = '{7'b0000000, 8'h2A, 7'b0000110, 8'hDD, 16'd1};
      vecs[8]  = '{7'b0000010, 8'h2A, 7'b0000001, 8'h2A, 16'd1};
      vecs[9]  = '{7'b0000000, 8'h05, 7'b0000001, 8'h2A, 16'd1};
      vecs[10] = '{7'b0000001, 8'h05, 7'b0000000, 8'h2A, 16'd2};
      vecs[11] = '{7'b1100000, 8'h05, 7'b0000000, 8'h2A, 16'd2};
      vecs[12] = '{7'b1000000, 8'h05, 7'b1000010, 8'h2A, 16'd2};
      vecs[13] = '{7'b0010000, 8'h05, 7'b0100010, 8'h2A, 16'd2};
      vecs[14] = '{7'b0100000, 8'h05, 7'b0000000, 8'h2A, 16'd2};
      vecs[15] = '{7'b0000000, 8'h05, 7'b0000000, 8'h2A, 16'd2};

      {bus.start, bus.abort, bus.clr_err, bus.cap_done, bus.fft_done, bus.det_done,
       bus.wb_done, bus.res_ready} = '0;
      bus.wb_doa = '0;

      #10;
      chk("reset_state", all_outs(), 40'd0);
      #2 reset_n = 1'b1;

      // nominal frame, stage dones 10 cycles apart, angle -35
      n_cs = 0; n_fs = 0; n_ds = 0; n_wg = 0;
      bus.start = 1'b1; step(); bus.start = 1'b0;
      chk("first_start", 40'(bus.cap_start), 40'd1);
      repeat (9) step();
      bus.cap_done = 1'b1; step(); bus.cap_done = 1'b0;
      repeat (9) step();
      bus.fft_done = 1'b1; step(); bus.fft_done = 1'b0;
      repeat (9) step();
      bus.det_done = 1'b1; step(); bus.det_done = 1'b0;
      repeat (9) step();
      bus.wb_doa = 8'hDD;
      bus.wb_done = 1'b1; step(); bus.wb_done = 1'b0;
      chk("nominal_result", 40'({bus.res_valid, bus.res_doa, bus.res_frame}), 40'({1'b1, 8'hDD, 16'd0}));
      bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0;
      repeat (2) step();
      chk("nominal_frame_inc", 40'({bus.res_valid, bus.busy, bus.res_frame}), 40'({1'b0, 1'b0, 16'd1}));
      chk("cap_start_pulses", 40'(n_cs), 40'd1);
      chk("fft_start_pulses", 40'(n_fs), 40'd1);
      chk("det_start_pulses", 40'(n_ds), 40'd1);
      chk("wb_go_pulses",     40'(n_wg), 40'd1);

      for (int i = 0; i < 16; i++) begin
         {bus.start, bus.abort, bus.cap_done, bus.fft_done, bus.det_done, bus.wb_done,
          bus.res_ready} = vecs[i].in_b;
         bus.wb_doa = vecs[i].doa_in;
         step();
         chk($sformatf("vec%0d", i),
             40'({bus.cap_start, bus.fft_start, bus.det_start, bus.wb_go, bus.ram_sel, bus.busy,
                  bus.res_valid, bus.res_doa, bus.res_frame}),
             40'({vecs[i].exp_b, vecs[i].exp_doa, vecs[i].exp_frame}));
      end
      {bus.start, bus.abort, bus.cap_done, bus.fft_done, bus.det_done, bus.wb_done,
       bus.res_ready} = '0;

      // FFT watchdog: ERROR on the 16th edge after FFT entry
      bus.start = 1'b1;    step(); bus.start = 1'b0;
      bus.cap_done = 1'b1; step(); bus.cap_done = 1'b0;
      chk("to_fft_start", 40'(bus.fft_start), 40'd1);
      repeat (15) step();
      chk("fft_before_expiry", 40'({bus.err, bus.busy}), 40'({1'b0, 1'b1}));
      step();
      chk("fft_timeout", 40'({bus.err, bus.err_stage, bus.busy}), 40'({1'b1, 3'd2, 1'b0}));
      bus.start = 1'b1; step(); bus.start = 1'b0;
      step();
      chk("error_holds", 40'({bus.err, bus.err_stage, bus.busy}), 40'({1'b1, 3'd2, 1'b0}));
      bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
      chk("clr_err", 40'({bus.err, bus.err_stage, bus.busy}), 40'd0);
      repeat (2) step();
      chk("pending_dropped_by_clr", 40'({bus.busy, bus.cap_start}), 40'd0);

      // fft_done on the expiry cycle wins over the timeout
      bus.start = 1'b1;    step(); bus.start = 1'b0;
      bus.cap_done = 1'b1; step(); bus.cap_done = 1'b0;
      repeat (15) step();
      bus.fft_done = 1'b1; step(); bus.fft_done = 1'b0;
      chk("done_beats_timeout", 40'({bus.det_start, bus.err, bus.busy}), 40'({1'b1, 1'b0, 1'b1}));
      step();
      chk("detect_ram_sel", 40'(bus.ram_sel), 40'd0);
      bus.abort = 1'b1; step(); bus.abort = 1'b0;
      chk("abort_detect", 40'({bus.ram_sel, bus.busy, bus.res_valid, bus.res_frame}), 40'({3'b000, 16'd2}));

      to_beam();
      chk("beam_ram_sel", 40'({bus.wb_go, bus.ram_sel}), 40'({1'b1, 1'b1}));
      step();
      bus.abort = 1'b1; step(); bus.abort = 1'b0;
      chk("abort_beam", 40'({bus.ram_sel, bus.busy, bus.res_valid, bus.res_frame}), 40'({3'b000, 16'd2}));

      // two starts in BEAM, result held 20 cycles, exactly one extra frame afterwards
      to_beam();
      bus.start = 1'b1; step(); bus.start = 1'b0;
      step();
      bus.start = 1'b1; step(); bus.start = 1'b0;
      bus.wb_doa = 8'hA6;
      bus.wb_done = 1'b1; step(); bus.wb_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus.wb_doa = 8'($urandom);
         step();
         chk($sformatf("hold_stable%0d", i), 40'({bus.res_valid, bus.res_doa, bus.res_frame}),
             40'({1'b1, 8'hA6, 16'd2}));
      end
      bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0;
      chk("pending_restart", 40'({bus.cap_start, bus.res_valid, bus.res_frame}), 40'({1'b1, 1'b0, 16'd3}));
      bus.cap_done = 1'b1; step(); bus.cap_done = 1'b0;
      bus.fft_done = 1'b1; step(); bus.fft_done = 1'b0;
      bus.det_done = 1'b1; step(); bus.det_done = 1'b0;
      bus.wb_doa = 8'h10;
      bus.wb_done = 1'b1; step(); bus.wb_done = 1'b0;
      chk("second_result", 40'({bus.res_valid, bus.res_doa}), 40'({1'b1, 8'h10}));
      bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0;
      repeat (3) step();
      chk("back_to_idle", 40'({bus.busy, bus.res_valid, bus.res_frame}), 40'({2'b00, 16'd4}));

      // CAPTURE timeout, then abort keeps the sticky error
      bus.start = 1'b1; step(); bus.start = 1'b0;
      repeat (16) step();
      chk("cap_timeout", 40'({bus.err, bus.err_stage}), 40'({1'b1, 3'd1}));
      bus.abort = 1'b1; step(); bus.abort = 1'b0;
      chk("abort_keeps_err", 40'({bus.err, bus.err_stage, bus.busy, bus.res_frame}),
          40'({1'b1, 3'd1, 1'b0, 16'd4}));

      // asynchronous reset between clock edges while in BEAM
      to_beam();
      chk("pre_reset_beam", 40'({bus.ram_sel, bus.busy}), 40'({1'b1, 1'b1}));
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset", all_outs(), 40'd0);
      #1 reset_n = 1'b1;
      bus.start = 1'b1; step(); bus.start = 1'b0;
      chk("start_after_reset", 40'({bus.cap_start, bus.busy}), 40'({1'b1, 1'b1}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/doa_sequencer.md
DOA_SEQUENCER -- requirements
Module: doa_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1048576, SHALL set the per-stage watchdog limit in clk cycles.
REQ-002 Parameter AUTO_RUN, default 0, SHALL make the block restart a frame on leaving HOLD without needing start when set to 1.
REQ-003 Ports SHALL be: clk  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  frame request; abort  in  1  return to IDLE; clr_err  in  1  clear sticky error.
REQ-005 cap_start  out  1  capture pulse; cap_done  in  1  capture complete pulse.
REQ-006 fft_start  out  1  FFT pulse; fft_done  in  1  FFT complete pulse.
REQ-007 det_start  out  1  frequency-detect pulse; det_done  in  1  maxbin valid pulse.
REQ-008 wb_go  out  1  beam-scan trigger pulse; wb_done  in  1  beam scan done pulse; wb_doa  in  8  signed angle, -90..90.
REQ-009 ram_sel  out  1  FFT RAM read-port owner: 0 = FFT/detect, 1 = beam scan.
REQ-010 res_valid  out  1; res_ready  in  1; res_doa  out  8 signed; res_frame  out  16; a valid/ready result channel.
REQ-011 busy  out  1; err  out  1 sticky; err_stage  out  3 stage code of the timeout.

Function
REQ-012 States SHALL be IDLE, CAPTURE, FFT, DETECT, BEAM, HOLD, ERROR; exactly one active.
REQ-013 IDLE->CAPTURE on start=1 (or pending=1); cap_start SHALL pulse exactly one cycle, on the first cycle in CAPTURE.
REQ-014 CAPTURE->FFT on cap_done; FFT->DETECT on fft_done; DETECT->BEAM on det_done; each entry SHALL pulse the matching *_start/wb_go for one cycle.
REQ-015 BEAM->HOLD on wb_done; res_doa SHALL latch wb_doa and res_valid SHALL rise the cycle after wb_done.
REQ-016 HOLD: res_valid, res_doa and res_frame SHALL stay stable until res_valid&&res_ready; on that cycle res_frame increments (wrap 65535->0) and the state goes to IDLE, or to CAPTURE if AUTO_RUN=1 or pending=1.
REQ-017 A start received in any state other than IDLE SHALL set a one-deep pending flag; further starts are dropped; pending clears when CAPTURE is entered.
REQ-018 ram_sel SHALL be 1 only in BEAM and SHALL change only on state transitions, never mid-stage.
REQ-019 busy SHALL be 1 in CAPTURE, FFT, DETECT and BEAM, and 0 otherwise.
REQ-020 Stage timer SHALL reset on every stage entry; on reaching TIMEOUT_CYCLES-1 without the stage's done signal, the block SHALL go to ERROR with err=1 and err_stage=1/2/3/4 for CAPTURE/FFT/DETECT/BEAM.
REQ-021 Done signal and timeout in the same cycle: done SHALL win.
REQ-022 Done pulses for a stage other than the current one SHALL be ignored.
REQ-023 ERROR SHALL hold until clr_err=1, then go to IDLE with err=0, err_stage=0 and pending=0.
REQ-024 abort=1 in any state SHALL go to IDLE next cycle, drop res_valid, clear pending, and preserve err; abort has priority over every other input.
REQ-025 ERROR and abort SHALL not increment res_frame.

Reset
REQ-026 On reset_n=0, asynchronously: state=IDLE; all *_start, wb_go, res_valid, busy, err=0; ram_sel=0; res_doa=0; res_frame=0; err_stage=0; pending=0; timer=0.
REQ-027 After reset_n rises, the first start SHALL be accepted on the first clk edge.

Structure
REQ-028 Package doa_pkg SHALL hold the state enum, the 3-bit stage-code constants, DOA_W=8 and FRAME_W=16.
REQ-029 One sub-module, stage_timer (load/clear, count, expire flag, parameter TIMEOUT_CYCLES), SHALL implement the watchdog.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 start pulse in IDLE, then cap/fft/det/wb done each 10 cycles apart, wb_doa=-35 -> one pulse each of cap_start, fft_start, det_start and wb_go; res_valid with res_doa=-35 and res_frame=0; after res_ready, res_frame=1.
REQ-032 TIMEOUT_CYCLES=16, withhold fft_done -> ERROR 16 cycles after FFT entry, err=1, err_stage=2; clr_err -> IDLE, err=0.
REQ-033 fft_done on exactly the expiry cycle -> DETECT entered, err stays 0.
REQ-034 Two starts during BEAM, res_ready held 0 for 20 cycles -> res_doa stable throughout; after the handshake exactly one new frame starts, then IDLE.
REQ-035 abort asserted in DETECT while ram_sel=0 and in BEAM while ram_sel=1 -> IDLE next cycle, ram_sel=0, busy=0, res_frame unchanged.
REQ-036 reset_n dropped mid-BEAM, asynchronously between clk edges -> all outputs take their REQ-026 values immediately, without waiting for a clk edge.
